wb_store_buffer: RTL and testbench

- Parametrised successor to the single-outstanding-store writeback path.
- Stores retiring from writeback enter a DEPTH-entry FIFO instead of stalling the pipeline for the whole D-cache round trip.
- The FIFO head drains to the D-cache one store at a time using the reqcyc/reqack/writeack handshake.
- Sits between the writeback stage and the D-cache core port; the pipeline stalls only when the buffer is full or draining.

---
 rtl/wb_store_buffer_if.sv | 24 ++
 rtl/wb_store_buffer.sv | 161 ++++++++++++++++
 tb/tb_wb_store_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_store_buffer_if.sv
// D-cache core-port bundle for the writeback store buffer.
// master = store buffer (request side), slave = D-cache.
interface wb_store_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              mem_reqcyc_out;
  logic [ADDR_W-1:0] mem_req_out;
  logic [DATA_W-1:0] mem_reqdata_out;
  logic [TAG_W-1:0]  mem_reqtag_out;
  logic              mem_reqack_in;
  logic              mem_writeack_in;

  modport master (
    output mem_reqcyc_out, mem_req_out, mem_reqdata_out, mem_reqtag_out,
    input  mem_reqack_in, mem_writeack_in
  );

  modport slave (
    input  mem_reqcyc_out, mem_req_out, mem_reqdata_out, mem_reqtag_out,
    output mem_reqack_in, mem_writeack_in
  );
endinterface

// File: rtl/wb_store_buffer.sv
// DEPTH-entry writeback store FIFO draining one store at a time to the D-cache.
// Optional store-to-load forwarding probe is enabled by defining STORE_FWD_EN.
module wb_store_buffer #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 13,
  // fields: op = WRITE, space = MEMORY, kind = DATA, then 7 zero bits
  parameter logic [TAG_W-1:0] WRITE_TAG = TAG_W'({2'b01, 2'b01, 2'b11, 7'b0000000})
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid_in,
  input  logic                       kill_in,
  input  logic                       is_store_in,
  input  logic [ADDR_W-1:0]          store_addr_in,
  input  logic [DATA_W-1:0]          store_data_in,
  input  logic                       drain_in,
  output logic                       wb_accept_out,
  output logic                       stall_out,
  output logic                       mem_write_done_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
`ifdef STORE_FWD_EN
  input  logic [ADDR_W-1:0]          fwd_addr_in,
  output logic                       fwd_hit_out,
  output logic [DATA_W-1:0]          fwd_data_out,
`endif
  wb_store_buffer_if.master          mem
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WACK = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic               reqcyc_q, reqcyc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [DATA_W-1:0]  req_data_q, req_data_d;
  logic               done_q, done_d;
  logic               present_s, full_s, enq_s, pop_s;

  // full looks at the registered count: a same-cycle pop never frees a slot
  assign present_s     = wb_valid_in & ~kill_in & is_store_in;
  assign full_s        = (count_q == CNT_W'(DEPTH));
  assign enq_s         = present_s & ~full_s & ~drain_in;
  assign wb_accept_out = wb_valid_in & ~kill_in & (~is_store_in | enq_s);
  assign stall_out     = present_s & ~enq_s;

  assign mem.mem_reqcyc_out  = reqcyc_q;
  assign mem.mem_req_out     = req_addr_q;
  assign mem.mem_reqdata_out = req_data_q;
  assign mem.mem_reqtag_out  = WRITE_TAG;
  assign mem_write_done_out  = done_q;
  assign count_out           = count_q;
  assign empty_out           = (count_q == {CNT_W{1'b0}}) & (state_q == IDLE);

  // issue FSM next-state and request register loads
  always_comb begin
    state_d    = state_q;
    reqcyc_d   = reqcyc_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != {CNT_W{1'b0}}) begin
          state_d    = REQ;
          reqcyc_d   = 1'b1;
          req_addr_d = addr_mem_q[rd_ptr_q];
          req_data_d = data_mem_q[rd_ptr_q];
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_reqack_in) begin
          reqcyc_d = 1'b0;
          if (mem.mem_writeack_in) begin
            pop_s   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WACK;
          end
        end else begin
          state_d = REQ;
        end
      end
      WACK: begin
        if (mem.mem_writeack_in) begin
          pop_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WACK;
        end
      end
      default: begin
        state_d  = IDLE;
        reqcyc_d = 1'b0;
      end
    endcase
    done_d  = pop_s;
    count_d = count_q + CNT_W'(enq_s) - CNT_W'(pop_s);
  end

  // control state, pointers and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      reqcyc_q   <= 1'b0;
      req_addr_q <= {ADDR_W{1'b0}};
      req_data_q <= {DATA_W{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= enq_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q   <= pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_q    <= count_d;
      reqcyc_q   <= reqcyc_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      done_q     <= done_d;
    end
  end

  // entry storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_q[wr_ptr_q] <= store_addr_in;
      data_mem_q[wr_ptr_q] <= store_data_in;
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx_s;

  // scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = {DATA_W{1'b0}};
    fwd_idx_s    = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem_q[fwd_idx_s] == fwd_addr_in)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = data_mem_q[fwd_idx_s];
      end else begin
        fwd_hit_out  = fwd_hit_out;
        fwd_data_out = fwd_data_out;
      end
    end
  end
`endif
endmodule

// File: tb/tb_wb_store_buffer.sv
// Directed bench for wb_store_buffer: vector table plus hand-written corner sequences.
module tb_wb_store_buffer;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int DEPTH = 4;
  localparam logic [TW-1:0] EXP_TAG = 13'h0B80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wb_valid, kill, is_store, drain;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          accept, stall, done, empty;
  logic [2:0]    count;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  wb_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) mem_if ();

  wb_store_buffer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW), .WRITE_TAG(EXP_TAG)
  ) dut (
    .clk(clk), .reset(reset), .wb_valid_in(wb_valid), .kill_in(kill),
    .is_store_in(is_store), .store_addr_in(st_addr), .store_data_in(st_data),
    .drain_in(drain), .wb_accept_out(accept), .stall_out(stall),
    .mem_write_done_out(done), .empty_out(empty), .count_out(count),
`ifdef STORE_FWD_EN
    .fwd_addr_in(fwd_addr), .fwd_hit_out(fwd_hit), .fwd_data_out(fwd_data),
`endif
    .mem(mem_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic v; logic k; logic s; logic d;
    logic acc; logic stl; int cnt;
  } vec_t;

  vec_t vt[12];
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic k, input logic s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = v; kill = k; is_store = s; st_addr = a; st_data = d;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // killed store
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0}; // non-store
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // no valid
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0}; // drain blocks
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2}; // killed store
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4}; // full
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4}; // non-store while full
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4}; // killed non-store

    reset = 1'b1; drain = 1'b0; fwd_addr = '0;
    present(1'b0, 1'b0, 1'b0, '0, '0);
    mem_if.mem_reqack_in = 1'b0; mem_if.mem_writeack_in = 1'b0;
    step(); step();
    chk("rst count", count, 0); chk("rst reqcyc", mem_if.mem_reqcyc_out, 0);
    chk("rst done", done, 0);   chk("rst empty", empty, 1);
    reset = 1'b0;

    // single store
    present(1'b1, 1'b0, 1'b1, 64'h1000, 64'hDEAD);
    #1 chk("single accept", accept, 1);
    step(); wb_valid = 1'b0;
    chk("single count", count, 1); chk("single reqcyc early", mem_if.mem_reqcyc_out, 0);
    chk("single not empty", empty, 0);
    step();
    chk("single reqcyc", mem_if.mem_reqcyc_out, 1); chk("single addr", mem_if.mem_req_out, 64'h1000);
    chk("single data", mem_if.mem_reqdata_out, 64'hDEAD); chk("single tag", mem_if.mem_reqtag_out, EXP_TAG);
    step(); chk("single reqcyc held", mem_if.mem_reqcyc_out, 1);
    mem_if.mem_reqack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0;
    chk("single reqcyc fall", mem_if.mem_reqcyc_out, 0); chk("single done early", done, 0);
    step(); step(); chk("single done wait", done, 0);
    mem_if.mem_writeack_in = 1'b1;
    step(); mem_if.mem_writeack_in = 1'b0;
    chk("single done", done, 1); chk("single empty", empty, 1); chk("single count0", count, 0);
    step(); chk("single done pulse", done, 0);

    // vector table, D-cache never acks
    for (int i = 0; i < 12; i++) begin
      present(vt[i].v, vt[i].k, vt[i].s, 64'h2000 + 64'(i * 16), 64'hA0 + 64'(i));
      drain = vt[i].d;
      #1;
      chk($sformatf("vec%0d accept", i), accept, vt[i].acc);
      chk($sformatf("vec%0d stall", i), stall, vt[i].stl);
      if (vt[i].v && !vt[i].k && vt[i].s && vt[i].acc) exp_q.push_back(st_addr);
      step();
      chk($sformatf("vec%0d count", i), count, vt[i].cnt);
    end
    wb_valid = 1'b0; drain = 1'b0;
    chk("table reqcyc", mem_if.mem_reqcyc_out, 1);
    chk("table head addr", mem_if.mem_req_out, exp_q[0]);
    chk("table head data", mem_if.mem_reqdata_out, 64'hA4);

    // fifth store waits for the first pop
    present(1'b1, 1'b0, 1'b1, 64'h3000, 64'h55);
    #1 chk("full stall", stall, 1); chk("full accept", accept, 0);
    mem_if.mem_reqack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0;
    chk("full wack reqcyc", mem_if.mem_reqcyc_out, 0); chk("full stall wack", stall, 1);
    mem_if.mem_writeack_in = 1'b1;
    #1 chk("full stall pop cycle", stall, 1);
    step(); mem_if.mem_writeack_in = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back(64'h3000);
    chk("full done", done, 1); chk("full count3", count, 3);
    chk("full accept after pop", accept, 1); chk("full stall after pop", stall, 0);
    step(); wb_valid = 1'b0;
    chk("full count4", count, 4); chk("full done pulse", done, 0);
    chk("order 2 reqcyc", mem_if.mem_reqcyc_out, 1); chk("order 2 addr", mem_if.mem_req_out, exp_q[0]);

    // reqack and writeack in the same cycle
    mem_if.mem_reqack_in = 1'b1; mem_if.mem_writeack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0; mem_if.mem_writeack_in = 1'b0;
    void'(exp_q.pop_front());
    chk("same done", done, 1); chk("same count", count, 3); chk("same reqcyc", mem_if.mem_reqcyc_out, 0);
    step();
    chk("same next reqcyc", mem_if.mem_reqcyc_out, 1); chk("same next addr", mem_if.mem_req_out, exp_q[0]);
    chk("same done pulse", done, 0);

    // reset while in WACK with 3 entries
    mem_if.mem_reqack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0;
    chk("rstmid count3", count, 3);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("rstmid count", count, 0); chk("rstmid reqcyc", mem_if.mem_reqcyc_out, 0);
    chk("rstmid empty", empty, 1);
    mem_if.mem_writeack_in = 1'b1;
    step(); mem_if.mem_writeack_in = 1'b0;
    chk("late wack done", done, 0); chk("late wack count", count, 0); chk("late wack empty", empty, 1);
    step(); chk("late wack reqcyc", mem_if.mem_reqcyc_out, 0);

    // drain: pending entry still drains while new stores stall
    present(1'b1, 1'b0, 1'b1, 64'h4000, 64'h77);
    step();
    present(1'b1, 1'b0, 1'b1, 64'h4008, 64'h88); drain = 1'b1;
    #1 chk("drain stall", stall, 1); chk("drain accept", accept, 0);
    step();
    chk("drain reqcyc", mem_if.mem_reqcyc_out, 1); chk("drain addr", mem_if.mem_req_out, 64'h4000);
    chk("drain count", count, 1);
    mem_if.mem_reqack_in = 1'b1; mem_if.mem_writeack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0; mem_if.mem_writeack_in = 1'b0;
    chk("drain done", done, 1); chk("drain empty", empty, 1); chk("drain still stall", stall, 1);
    drain = 1'b0;
    #1 chk("drain release accept", accept, 1);
    step(); wb_valid = 1'b0;
    step(); chk("drain next addr", mem_if.mem_req_out, 64'h4008);
    mem_if.mem_reqack_in = 1'b1; mem_if.mem_writeack_in = 1'b1;
    step(); mem_if.mem_reqack_in = 1'b0; mem_if.mem_writeack_in = 1'b0;
    chk("drain final empty", empty, 1);

`ifdef STORE_FWD_EN
    present(1'b1, 1'b0, 1'b1, 64'h40, 64'h11);
    step();
    present(1'b1, 1'b0, 1'b1, 64'h40, 64'h22);
    step(); wb_valid = 1'b0;
    fwd_addr = 64'h40;
    #1 chk("fwd hit", fwd_hit, 1); chk("fwd data", fwd_data, 64'h22);
    fwd_addr = 64'h48;
    #1 chk("fwd miss hit", fwd_hit, 0); chk("fwd miss data", fwd_data, 0);
    reset = 1'b1; step(); reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
